// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational ROM address and registers the returned word into IR.
// Optional NOP timed-delay enabled by defining FETCH_NOP_DELAY_EN.
module instruction_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid
);

  // state   | meaning
  // FETCH   | normal sequential fetch, or holding under stall
  // FLUSH   | bubble cycle right after a branch redirect
  // DELAY   | NOP timed-delay countdown, PC frozen
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;

  localparam int         OPR_W  = INSTR_W - 4;
  localparam logic [3:0] OP_NOP = 4'h0;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic               valid_q, valid_d;
`ifdef FETCH_NOP_DELAY_EN
  logic [OPR_W-1:0]   cnt_q, cnt_d;
  logic               nop_hit;

  assign nop_hit = valid_q && (ir_q[INSTR_W-1 -: 4] == OP_NOP) && (ir_q[OPR_W-1:0] != '0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opc_d   = opc_q;
    valid_d = valid_q;
`ifdef FETCH_NOP_DELAY_EN
    cnt_d   = cnt_q;
`endif
    if (iBranchTaken) begin
      pc_d    = iBranchTarget;
      valid_d = 1'b0;
      state_d = S_FLUSH;
`ifdef FETCH_NOP_DELAY_EN
      cnt_d   = '0;
    end else if (state_q == S_DELAY && cnt_q != '0) begin
      cnt_d = cnt_q - OPR_W'(1);
    end else if (state_q != S_DELAY && nop_hit) begin
      state_d = S_DELAY;
      cnt_d   = ir_q[OPR_W-1:0] - OPR_W'(1);
      valid_d = 1'b0;
`endif
    end else begin
      // Leaving DELAY always returns to FETCH, even if the stall keeps this edge idle.
      if (!iStall || state_q == S_DELAY) state_d = S_FETCH;
      if (!iStall) begin
        ir_d    = iInstruction;
        opc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= {OP_NOP, {OPR_W{1'b0}}};
      opc_q   <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_NOP_DELAY_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
`ifdef FETCH_NOP_DELAY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = ir_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: abstract fetch model checked every cycle plus directed literal checks.
// Honours FETCH_NOP_DELAY_EN the same way the design does.
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = '0;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;

  int errors = 0;
  int checks = 0;

  instruction_fetch dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid)
  );

  always #5 Clock = ~Clock;

  // ROM: a NOP with operand 4 lives at 0x0010, every other word is opcode A carrying its address.
  function automatic logic [27:0] rom(input logic [15:0] a);
    if (a == 16'h0010) return {4'h0, 24'd4};
    return {4'hA, 8'h00, a};
  endfunction

  assign iInstruction = rom(oAddress);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: the PC, what the IR shows, and how many dead cycles remain.
  logic [15:0] m_pc = '0, m_opc = '0;
  logic [27:0] m_ir = '0;
  logic        m_valid = 1'b0;
  int          m_dead = 0;
  bit          m_live = 0;

  always @(posedge Clock) begin
    bit do_fetch;
    do_fetch = 0;
    m_live = 1;
    if (Reset) begin
      m_pc = 16'h0000; m_ir = '0; m_opc = '0; m_valid = 0; m_dead = 0;
    end else if (iBranchTaken) begin
      m_pc = iBranchTarget; m_valid = 0; m_dead = 0;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) do_fetch = 1;
`ifdef FETCH_NOP_DELAY_EN
    end else if (m_valid && m_ir[27:24] == 4'h0 && m_ir[23:0] != 0) begin
      m_dead = int'(m_ir[23:0]);
      m_valid = 0;
`endif
    end else begin
      do_fetch = 1;
    end
    if (do_fetch && !iStall) begin
      m_ir = rom(m_pc); m_opc = m_pc; m_valid = 1; m_pc = m_pc + 16'd1;
    end
  end

  always @(negedge Clock) begin
    if (m_live) begin
      chk("model_addr", 32'(oAddress), 32'(m_pc));
      chk("model_valid", 32'(oValid), 32'(m_valid));
      chk("model_instr", 32'(oInstruction), 32'(m_ir));
      chk("model_pc", 32'(oPC), 32'(m_opc));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    int zeros;
    tick(3);
    chk("reset_addr", 32'(oAddress), 32'h0);
    chk("reset_valid", 32'(oValid), 32'h0);
    chk("reset_instr", 32'(oInstruction), 32'h0);
    Reset = 1'b0;
    tick(1);
    chk("first_valid", 32'(oValid), 32'h1);
    chk("first_pc", 32'(oPC), 32'h0);
    chk("first_addr", 32'(oAddress), 32'h1);
    chk("first_instr", 32'(oInstruction), 32'hA000000);
    tick(4);
    chk("seq_addr5", 32'(oAddress), 32'h5);

    iStall = 1'b1;
    tick(4);
    chk("stall_addr", 32'(oAddress), 32'h5);
    chk("stall_pc", 32'(oPC), 32'h4);
    chk("stall_instr", 32'(oInstruction), 32'hA000004);
    iStall = 1'b0;
    tick(1);
    chk("resume_addr", 32'(oAddress), 32'h6);
    chk("resume_pc", 32'(oPC), 32'h5);

    iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'h0000;
    tick(1);
    chk("br_addr", 32'(oAddress), 32'h0);
    chk("br_bubble", 32'(oValid), 32'h0);
    iStall = 1'b0; iBranchTaken = 1'b0;
    tick(1);
    chk("br_valid", 32'(oValid), 32'h1);
    chk("br_pc", 32'(oPC), 32'h0);

    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    tick(1);
    iBranchTaken = 1'b0;
    tick(1);
    chk("wrap_pc", 32'(oPC), 32'hFFFF);
    chk("wrap_addr", 32'(oAddress), 32'h0);
    tick(1);
    chk("wrap_pc0", 32'(oPC), 32'h0);

    iBranchTaken = 1'b1; iBranchTarget = 16'h0010;
    tick(1);
    iBranchTaken = 1'b0;
    tick(1);
    chk("nop_fetched", 32'(oInstruction), 32'h0000004);
    zeros = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (!oValid) zeros++;
    end
`ifdef FETCH_NOP_DELAY_EN
    chk("nop_dead_cycles", 32'(zeros), 32'd4);

    iBranchTaken = 1'b1; iBranchTarget = 16'h0010;
    tick(1);
    iBranchTaken = 1'b0;
    tick(3);
    chk("delay_frozen", 32'(oAddress), 32'h11);
    iBranchTaken = 1'b1; iBranchTarget = 16'h0040;
    tick(1);
    iBranchTaken = 1'b0;
    chk("abort_addr", 32'(oAddress), 32'h40);
    chk("abort_valid", 32'(oValid), 32'h0);
    tick(1);
    chk("abort_pc", 32'(oPC), 32'h40);

    iBranchTaken = 1'b1; iBranchTarget = 16'h0010;
    tick(1);
    iBranchTaken = 1'b0;
    tick(4);
    Reset = 1'b1;
    tick(1);
    chk("rst_delay_addr", 32'(oAddress), 32'h0);
    chk("rst_delay_valid", 32'(oValid), 32'h0);
    Reset = 1'b0;
    tick(2);
    chk("rst_delay_resume", 32'(oPC), 32'h1);
`else
    chk("nop_dead_cycles", 32'(zeros), 32'd0);
    chk("nop_pass_addr", 32'(oAddress), 32'h1D);
    chk("nop_pass_pc", 32'(oPC), 32'h1C);
`endif
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
